// File: rtl/rv32i_wb_master.sv
// ---------------------------------------------------------------------------
// rv32i_wb_master
//
// Memory-stage Wishbone classic master. Each accepted load/store request
// becomes exactly one non-pipelined Wishbone cycle, or an immediate error
// response if the access is misaligned or has an illegal size.
//
// Handshakes:
//   req_valid_i / req_ready_o     request accepted on an edge with both high;
//                                 ready only while idle.
//   resp_valid_o                  single-cycle completion pulse. There is no
//                                 backpressure, so the consumer must take it.
//
// Ports:
//   clk_i, rst_i                  clock (rising edge), async active-high reset
//   req_we_i                      1 = store, 0 = load
//   req_addr_i                    byte address
//   req_wdata_i                   store data, right-aligned
//   req_size_i                    00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i                load zero-extends when 1, sign-extends when 0
//   resp_rdata_o                  extended load data; 0 for stores and errors
//   resp_err_o                    completion is an error
//   resp_cause_o                  00 ok, 01 misaligned/illegal size,
//                                 10 bus error, 11 timeout
//   adr_o, dat_o, sel_o, we_o     Wishbone word address, steered data,
//                                 lane select and write enable
//   cyc_o, stb_o                  Wishbone cycle/strobe (always equal)
//   dat_i, ack_i, err_i           Wishbone slave read data, ack and error
//
// Parameters:
//   XLEN     data/address width; only 32 (four byte lanes) is supported
//   TIMEOUT  cycles to wait for ack/err before aborting; 0 disables it
// ---------------------------------------------------------------------------
module rv32i_wb_master #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic [1:0]      resp_cause_o,
  output logic [XLEN-3:0] adr_o,
  output logic [XLEN-1:0] dat_o,
  input  logic [XLEN-1:0] dat_i,
  output logic [3:0]      sel_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  input  logic            ack_i,
  input  logic            err_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  typedef enum logic [1:0] {
    C_OK       = 2'b00,
    C_MISALIGN = 2'b01,
    C_BUSERR   = 2'b10,
    C_TIMEOUT  = 2'b11
  } cause_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // The counter holds TIMEOUT-1 during the last BUS cycle the slave is given.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t          state_q, state_d;
  cause_t          cause_q, cause_d;
  logic [XLEN-3:0] adr_q,   adr_d;
  logic [XLEN-1:0] dat_q,   dat_d;
  logic [3:0]      sel_q,   sel_d;
  logic            we_q,    we_d;
  logic            cyc_q,   cyc_d;
  logic [1:0]      off_q,   off_d;
  logic [1:0]      size_q,  size_d;
  logic            uns_q,   uns_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            misaligned;
  logic            bus_exit;
  logic [3:0]      sel_new;
  logic [XLEN-1:0] dat_new;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] load_ext;

  // Lane select and write-data steering for the incoming request.
  always_comb begin
    misaligned = (req_size_i == 2'b11) ||
                 (req_size_i == 2'b01 && req_addr_i[0]) ||
                 (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
    case (req_size_i)
      2'b00: begin
        sel_new = 4'b0001 << req_addr_i[1:0];
        dat_new = XLEN'(req_wdata_i[7:0]) << {req_addr_i[1:0], 3'b000};
      end
      2'b01: begin
        sel_new = 4'b0011 << req_addr_i[1:0];
        dat_new = XLEN'(req_wdata_i[15:0]) << {req_addr_i[1], 4'b0000};
      end
      default: begin
        sel_new = 4'b1111;
        dat_new = req_wdata_i;
      end
    endcase
  end

  // Read-data extraction: pick the addressed lane, then extend.
  always_comb begin
    byte_lane = 8'(dat_i >> {off_q, 3'b000});
    half_lane = 16'(dat_i >> {off_q[1], 4'b0000});
    case (size_q)
      2'b00:   load_ext = uns_q ? {{(XLEN-8){1'b0}}, byte_lane}
                                : {{(XLEN-8){byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = uns_q ? {{(XLEN-16){1'b0}}, half_lane}
                                : {{(XLEN-16){half_lane[15]}}, half_lane};
      default: load_ext = dat_i;
    endcase
  end

  // Next-state logic.
  // NOTE: every variable gets a default before the case; a path that leaves
  // one unassigned would infer a latch instead of combinational logic.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    cyc_d    = cyc_q;
    off_d    = off_q;
    size_d   = size_q;
    uns_d    = uns_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    bus_exit = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          off_d   = req_addr_i[1:0];
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          rdata_d = '0;
          cnt_d   = '0;
          if (misaligned) begin
            cause_d = C_MISALIGN;
            state_d = S_RESP;
          end else begin
            cause_d = C_OK;
            adr_d   = req_addr_i[XLEN-1:2];
            sel_d   = sel_new;
            dat_d   = dat_new;
            we_d    = req_we_i;
            cyc_d   = 1'b1;
            state_d = S_BUS;
          end
        end
      end

      S_BUS: begin
        cnt_d = cnt_q + CW'(1);
        // err beats ack, and either beats a timeout landing on the same edge.
        if (err_i) begin
          cause_d  = C_BUSERR;
          bus_exit = 1'b1;
        end else if (ack_i) begin
          cause_d  = C_OK;
          bus_exit = 1'b1;
          if (!we_q) rdata_d = load_ext;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          cause_d  = C_TIMEOUT;
          bus_exit = 1'b1;
        end
        if (bus_exit) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          dat_d   = '0;
          adr_d   = '0;
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end

      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cause_q <= C_OK;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Ready is held low while reset is asserted so nothing is accepted then.
  assign req_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_err_o   = resp_valid_o && (cause_q != C_OK);
  assign resp_cause_o = resp_valid_o ? cause_q : C_OK;
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;

  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign sel_o = sel_q;
  assign we_o  = we_q;
  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;

endmodule

// File: tb/tb_rv32i_wb_master.sv
// ---------------------------------------------------------------------------
// tb_rv32i_wb_master
//
// Table-driven bench for rv32i_wb_master (TIMEOUT = 4). Each record is one
// request with the slave behaviour to play back and the hand-computed bus
// and response values. Reset, mid-bus reset and stray ack/err are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_rv32i_wb_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [1:0]  resp_cause_o;
  logic [29:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic        ack_i;
  logic        err_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  rv32i_wb_master #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .resp_cause_o   (resp_cause_o),
    .adr_o          (adr_o),
    .dat_o          (dat_o),
    .dat_i          (dat_i),
    .sel_o          (sel_o),
    .cyc_o          (cyc_o),
    .stb_o          (stb_o),
    .we_o           (we_o),
    .ack_i          (ack_i),
    .err_i          (err_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    int          bus_cycles;  // cycles cyc_o stays high; slave answers in the last
    logic        ack;
    logic        err;
    logic [31:0] rd;          // dat_i driven in the answering cycle
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    logic [1:0]  exp_cause;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d_", idx);
    check({p, "ready_idle"}, 32'(req_ready_o), 32'd1);
    req_valid_i    = 1'b1;
    req_we_i       = v.we;
    req_addr_i     = v.addr;
    req_wdata_i    = v.wdata;
    req_size_i     = v.size;
    req_unsigned_i = v.uns;
    @(posedge clk_i); #1;
    // Request ignored from here on; scramble it to prove outputs are held.
    req_valid_i = 1'b0;
    req_addr_i  = 32'hFFFF_FFFF;
    req_wdata_i = 32'h5A5A_5A5A;
    req_size_i  = 2'b11;
    if (v.exp_cause == 2'b01) begin
      check({p, "mis_valid"}, 32'(resp_valid_o), 32'd1);
      check({p, "mis_err"},   32'(resp_err_o),   32'd1);
      check({p, "mis_cause"}, 32'(resp_cause_o), 32'd1);
      check({p, "mis_rdata"}, resp_rdata_o,      32'd0);
      check({p, "mis_cyc"},   32'(cyc_o),        32'd0);
      @(posedge clk_i); #1;
      check({p, "mis_pulse"}, 32'(resp_valid_o), 32'd0);
      check({p, "mis_ready"}, 32'(req_ready_o),  32'd1);
      return;
    end
    check({p, "cyc"},   32'(cyc_o),        32'd1);
    check({p, "stb"},   32'(stb_o),        32'd1);
    check({p, "we"},    32'(we_o),         32'(v.we));
    check({p, "adr"},   32'(adr_o),        v.addr >> 2);
    check({p, "sel"},   32'(sel_o),        32'(v.exp_sel));
    check({p, "dat"},   dat_o,             v.exp_dat);
    check({p, "busy"},  32'(req_ready_o),  32'd0);
    check({p, "nores"}, 32'(resp_valid_o), 32'd0);
    for (int c = 1; c < v.bus_cycles; c++) begin
      @(posedge clk_i); #1;
      check({p, "cyc_hold"}, 32'(cyc_o), 32'd1);
      check({p, "sel_hold"}, 32'(sel_o), 32'(v.exp_sel));
    end
    ack_i = v.ack;
    err_i = v.err;
    dat_i = v.rd;
    @(posedge clk_i); #1;
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = 32'hA5A5_5A5A;
    check({p, "cyc_drop"},   32'(cyc_o),        32'd0);
    check({p, "stb_drop"},   32'(stb_o),        32'd0);
    check({p, "sel_drop"},   32'(sel_o),        32'd0);
    check({p, "we_drop"},    32'(we_o),         32'd0);
    check({p, "resp_valid"}, 32'(resp_valid_o), 32'd1);
    check({p, "resp_cause"}, 32'(resp_cause_o), 32'(v.exp_cause));
    check({p, "resp_err"},   32'(resp_err_o),   32'(v.exp_cause != 2'b00));
    check({p, "resp_rdata"}, resp_rdata_o,      v.exp_rdata);
    @(posedge clk_i); #1;
    check({p, "resp_pulse"}, 32'(resp_valid_o), 32'd0);
    check({p, "ready_back"}, 32'(req_ready_o),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            addr          we    wdata         sz     u     cyc ack   err   rd            sel      dat           cause  rdata
    vecs[0]  = '{32'h0000_1004, 1'b0, 32'h0,        2'b10, 1'b0, 2, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0,        2'b00, 32'hDEAD_BEEF};
    vecs[1]  = '{32'h0000_2003, 1'b0, 32'h0,        2'b00, 1'b0, 2, 1'b1, 1'b0, 32'h80FF_FFFF, 4'b1000, 32'h0,        2'b00, 32'hFFFF_FF80};
    vecs[2]  = '{32'h0000_2003, 1'b0, 32'h0,        2'b00, 1'b1, 2, 1'b1, 1'b0, 32'h80FF_FFFF, 4'b1000, 32'h0,        2'b00, 32'h0000_0080};
    vecs[3]  = '{32'h0000_3002, 1'b1, 32'h1234_ABCD, 2'b01, 1'b0, 2, 1'b1, 1'b0, 32'h5555_5555, 4'b1100, 32'hABCD_0000, 2'b00, 32'h0};
    vecs[4]  = '{32'h0000_4001, 1'b1, 32'h1122_3344, 2'b00, 1'b0, 1, 1'b1, 1'b0, 32'h5555_5555, 4'b0010, 32'h0000_4400, 2'b00, 32'h0};
    vecs[5]  = '{32'h0000_5000, 1'b0, 32'h0,        2'b01, 1'b0, 3, 1'b1, 1'b0, 32'h1234_8001, 4'b0011, 32'h0,        2'b00, 32'hFFFF_8001};
    vecs[6]  = '{32'h0000_5002, 1'b0, 32'h0,        2'b01, 1'b1, 2, 1'b1, 1'b0, 32'hBEEF_0000, 4'b1100, 32'h0,        2'b00, 32'h0000_BEEF};
    vecs[7]  = '{32'h0000_6001, 1'b0, 32'h0,        2'b00, 1'b0, 2, 1'b1, 1'b0, 32'h0000_7F00, 4'b0010, 32'h0,        2'b00, 32'h0000_007F};
    vecs[8]  = '{32'h0000_7000, 1'b1, 32'hCAFE_F00D, 2'b10, 1'b0, 1, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hCAFE_F00D, 2'b00, 32'h0};
    vecs[9]  = '{32'h0000_8001, 1'b0, 32'h0,        2'b10, 1'b0, 0, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        2'b01, 32'h0};
    vecs[10] = '{32'h0000_9000, 1'b0, 32'h0,        2'b11, 1'b0, 0, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        2'b01, 32'h0};
    vecs[11] = '{32'h0000_A001, 1'b0, 32'h0,        2'b01, 1'b0, 0, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        2'b01, 32'h0};
    vecs[12] = '{32'h0000_C004, 1'b0, 32'h0,        2'b10, 1'b0, 2, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b1111, 32'h0,        2'b10, 32'h0};
    // Ack in the fourth bus cycle wins over the timeout firing on that edge.
    vecs[13] = '{32'h0000_D008, 1'b0, 32'h0,        2'b10, 1'b0, 4, 1'b1, 1'b0, 32'h0BAD_F00D, 4'b1111, 32'h0,        2'b00, 32'h0BAD_F00D};
    // Silent slave: cyc_o high four cycles, then timeout.
    vecs[14] = '{32'h0000_B000, 1'b0, 32'h0,        2'b10, 1'b0, 4, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1111, 32'h0,        2'b11, 32'h0};

    rst_i          = 1'b1;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    req_size_i     = '0;
    req_unsigned_i = 1'b0;
    dat_i          = '0;
    ack_i          = 1'b0;
    err_i          = 1'b0;

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_cyc",   32'(cyc_o),        32'd0);
    check("rst_valid", 32'(resp_valid_o), 32'd0);
    check("rst_sel",   32'(sel_o),        32'd0);
    check("rst_we",    32'(we_o),         32'd0);
    rst_i = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;

    // Stray ack/err while idle must not produce a response.
    ack_i = 1'b1;
    err_i = 1'b1;
    repeat (2) begin
      @(posedge clk_i); #1;
      check("stray_valid", 32'(resp_valid_o), 32'd0);
      check("stray_ready", 32'(req_ready_o),  32'd1);
    end
    ack_i = 1'b0;
    err_i = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a bus cycle: cyc_o drops without a clock edge.
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 32'h0000_E000;
    req_size_i  = 2'b10;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("mrst_cyc_before", 32'(cyc_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("mrst_cyc_async", 32'(cyc_o), 32'd0);
    check("mrst_stb_async", 32'(stb_o), 32'd0);
    check("mrst_sel_async", 32'(sel_o), 32'd0);
    repeat (2) begin
      @(posedge clk_i); #1;
      check("mrst_no_resp", 32'(resp_valid_o), 32'd0);
    end
    #2 rst_i = 1'b0;
    #1;
    check("mrst_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;
    check("mrst_no_resp_after", 32'(resp_valid_o), 32'd0);
    run_vec(100, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_wb_master.md
Name: rv32i_wb_master

Overview:
Memory-stage Wishbone classic master for the rv32i pipeline. Converts one load/store request from the pipeline into a single non-pipelined Wishbone cycle: byte-lane select generation, write-data lane steering, read-data extraction with sign/zero extension. Reports misalignment, bus error and timeout. Sits directly upstream of every rv32i_wb slave (through the interconnect) and downstream of the execute stage.

Parameters:
XLEN, 32, data/address width; only 32 supported (4 byte lanes).
TIMEOUT, 255, max cycles waiting for ack/err before abort; 0 disables timeout.

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  pipeline request present
req_ready_o  out  1  high when idle; request accepted on edge where valid & ready
req_we_i  in  1  1 = store, 0 = load
req_addr_i  in  XLEN  byte address
req_wdata_i  in  XLEN  store data, right-aligned
req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  XLEN  extended load data; 0 for stores and errors
resp_err_o  out  1  completion is an error (valid with resp_valid_o)
resp_cause_o  out  2  00 ok, 01 misaligned/illegal size, 10 bus err, 11 timeout
adr_o  out  XLEN-2  word address (req_addr_i[XLEN-1:2])
dat_o  out  XLEN  lane-steered write data
dat_i  in  XLEN  slave read data
sel_o  out  4  byte-lane select
cyc_o  out  1  bus cycle
stb_o  out  1  strobe (equals cyc_o)
we_o  out  1  write enable
ack_i  in  1  slave ack
err_i  in  1  slave error

Behaviour:
- Reset (async): state IDLE; req_ready_o=1 after release; all other outputs 0, timeout counter 0. Reset during BUS drops cyc_o/stb_o immediately; no response generated.
- States: IDLE, BUS, RESP.
- IDLE: req_ready_o=1. On valid&ready: if size=11, or half with addr[0]=1, or word with addr[1:0]!=0 -> RESP, cause 01, no bus cycle. Else register adr_o, sel_o, dat_o, we_o, byte offset, size, unsigned; set cyc_o=stb_o=1 -> BUS.
- sel_o: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. dat_o: byte wdata[7:0]<<8*addr[1:0]; half wdata[15:0]<<16*addr[1]; word unchanged. Unselected lanes 0.
- BUS: req_ready_o=0; outputs stable. err_i (priority over ack_i if both high) -> cause 10. ack_i -> cause 00, capture dat_i. Counter increments each BUS cycle; when counter reaches TIMEOUT with no ack/err (TIMEOUT>0) -> cause 11. On any exit: cyc_o, stb_o, we_o, sel_o cleared on same edge -> RESP; counter cleared.
- RESP: resp_valid_o=1 for exactly one cycle with resp_err_o=(cause!=00). Loads: lane selected by stored offset, extended to XLEN per size/unsigned; word passes through. Stores/errors: rdata 0. Next edge -> IDLE. No backpressure on response; consumer must take it.
- Latency (registered slave acking one cycle after stb): accept edge N, cyc_o high cycles N+1..N+2, ack in N+2, resp_valid_o in cycle N+3. Misaligned: resp_valid_o in cycle N+1.
- ack_i/err_i outside BUS are ignored. req_* ignored when req_ready_o=0.

Test Plan:
- Word load addr 0x0000_1004, slave returns 0xDEADBEEF -> adr_o=0x401, sel_o=1111, we_o=0; resp_rdata_o=0xDEADBEEF, cause 00, resp 3 cycles after accept.
- Byte load signed addr 0x...03, dat_i=0x80FF_FFFF -> sel_o=1000, rdata=0xFFFF_FF80; same unsigned -> 0x0000_0080.
- Half store addr 0x...02 wdata 0x1234_ABCD -> sel_o=1100, dat_o=0xABCD_0000, we_o=1; resp rdata 0, cause 00.
- Word load addr 0x...01 and size=11 -> no cyc_o, resp_err_o=1, cause 01 one cycle after accept.
- TIMEOUT=4, slave never acks -> cyc_o high 4 cycles then drops, cause 11; err_i and ack_i together -> cause 10.
- Assert rst_i mid-BUS -> cyc_o falls without clock edge, no resp_valid_o; next request after release completes normally.
